regfile_scoreboard: RTL

//  Decode-side register file and hazard scoreboard; terminates the writeback port (rd/rd_data/rd_w_v).
//  Two combinational read ports feed decode operands. 32-bit pending-write scoreboard raises hazard_v_o

---
 rtl/regfile_scoreboard.sv | 66 ++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: decode register file with pending-write hazard scoreboard; RVGA_REGFILE_BYPASS_EN adds same-cycle writeback bypass
module regfile_scoreboard #(
   parameter int width_p      = 32,
   parameter int regs_p       = 32,
   parameter int addr_width_p = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [addr_width_p-1:0] rs1_i,
   input  logic [addr_width_p-1:0] rs2_i,
   output logic [width_p-1:0]      rs1_data_o,
   output logic [width_p-1:0]      rs2_data_o,
   output logic                    hazard_v_o,
   input  logic                    issue_v_i,
   input  logic [addr_width_p-1:0] issue_rd_i,
   input  logic                    issue_rd_w_v_i,
   input  logic                    flush_i,
   input  logic [addr_width_p-1:0] rd_i,
   input  logic [width_p-1:0]      rd_data_i,
   input  logic                    rd_w_v_i,
   output logic [regs_p-1:0]       pending_o
);
   logic [width_p-1:0] regs_q [regs_p];
   logic [width_p-1:0] regs_d [regs_p];
   logic [regs_p-1:0]  pending_q, pending_d;
   logic               wb_hit1, wb_hit2, issue_fire;
`ifdef RVGA_REGFILE_BYPASS_EN
   assign wb_hit1 = rd_w_v_i && (rd_i == rs1_i);
   assign wb_hit2 = rd_w_v_i && (rd_i == rs2_i);
`else
   assign wb_hit1 = 1'b0;
   assign wb_hit2 = 1'b0;
`endif
   assign hazard_v_o = ((rs1_i != '0) && pending_q[rs1_i] && !wb_hit1) ||
                       ((rs2_i != '0) && pending_q[rs2_i] && !wb_hit2);
   assign rs1_data_o = (rs1_i == '0) ? '0 : wb_hit1 ? rd_data_i : regs_q[rs1_i];
   assign rs2_data_o = (rs2_i == '0) ? '0 : wb_hit2 ? rd_data_i : regs_q[rs2_i];
   assign issue_fire = issue_v_i && issue_rd_w_v_i && (issue_rd_i != '0) && !hazard_v_o;
   assign pending_o  = pending_q;
   // writeback into the array; x0 is never written
   always_comb begin
      regs_d = regs_q;
      if (rd_w_v_i && (rd_i != '0)) regs_d[rd_i] = rd_data_i;
   end
   // per-register pending bit: flush, then issue set, then writeback clear
   always_comb begin
      pending_d = pending_q;
      for (int n = 0; n < regs_p; n++) begin
         pending_d[n] = (n == 0) ? 1'b0 :
                        flush_i ? 1'b0 :
                        (issue_fire && (issue_rd_i == addr_width_p'(n))) ? 1'b1 :
                        (rd_w_v_i && (rd_i == addr_width_p'(n))) ? 1'b0 :
                        pending_q[n];
      end
   end
   // state registers, cleared asynchronously
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pending_q <= '0;
         for (int n = 0; n < regs_p; n++) regs_q[n] <= '0;
      end else begin
         pending_q <= pending_d;
         regs_q    <= regs_d;
      end
   end
endmodule
